// File: rtl/tjrpu_mem_pkg.sv
// Shared constants and FSM state type for the tjrpu SRAM arbiter.
package tjrpu_mem_pkg;

    localparam int unsigned DEF_ADDR_W    = 9;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;
    localparam logic [31:0] DEF_ADDR_MASK = 32'hFFFF_F800;

    typedef enum logic [1:0] {
        IDLE,
        H_WAIT,
        H_ACK
    } arb_state_t;

    function automatic logic addr_hit(input logic [31:0] adr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
        return (adr & mask) == base;
    endfunction

endpackage

// File: rtl/tjrpu_rr_arb2.sv
// Two-way round-robin picker; requester b can be locked out, last_a remembers who won.
module tjrpu_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic lock_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic last_a
);

    logic req_b_ok;

    // a loses a tie only when it won the previous grant
    always_comb begin
        req_b_ok = req_b & ~lock_b & ~rst;
        gnt_a    = req_a & ~rst & (~req_b_ok | ~last_a);
        gnt_b    = req_b_ok & ~gnt_a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_a <= 1'b0;
        end else if (gnt_a) begin
            last_a <= 1'b1;
        end else if (gnt_b) begin
            last_a <= 1'b0;
        end
    end

endmodule

// File: rtl/tjrpu_mem_arbiter.sv
// Shares one single-port SRAM between the Wishbone host slave and the tjrpu core port.
module tjrpu_mem_arbiter
    import tjrpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [31:0] ADDR_MASK = DEF_ADDR_MASK
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    input  logic              host_excl_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [3:0]        core_be_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [31:0]       core_wdata_i,
    output logic              core_gnt_o,
    output logic              core_rvalid_o,
    output logic [31:0]       core_rdata_o,
    output logic              sram_en_o,
    output logic              sram_we_o,
    output logic [3:0]        sram_be_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    input  logic [31:0]       sram_rdata_i
);

    arb_state_t        state;
    arb_state_t        state_next;
    logic              host_pend;
    logic              host_gnt;
    logic              core_gnt;
    logic              rr_last_host;
    logic [ADDR_W-1:0] host_word;

    assign host_pend = wbs_cyc_i & wbs_stb_i & (state == IDLE)
                     & addr_hit(wbs_adr_i, BASE_ADDR, ADDR_MASK);
    assign host_word = wbs_adr_i[ADDR_W+1:2];

    tjrpu_rr_arb2 u_rr (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .req_a  (host_pend),
        .req_b  (core_req_i),
        .lock_b (host_excl_i),
        .gnt_a  (host_gnt),
        .gnt_b  (core_gnt),
        .last_a (rr_last_host)
    );

    assign core_gnt_o   = core_gnt;
    assign core_rdata_o = sram_rdata_i;

    // SRAM port mux; idle cycles drive zeros so the macro pins stay quiet
    always_comb begin
        sram_en_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_be_o    = '0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (host_gnt) begin
            sram_en_o    = 1'b1;
            sram_we_o    = wbs_we_i;
            sram_be_o    = wbs_sel_i;
            sram_addr_o  = host_word;
            sram_wdata_o = wbs_dat_i;
        end else if (core_gnt) begin
            sram_en_o    = 1'b1;
            sram_we_o    = core_we_i;
            sram_be_o    = core_be_i;
            sram_addr_o  = core_addr_i;
            sram_wdata_o = core_wdata_i;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (host_gnt) state_next = H_WAIT;
            H_WAIT:  state_next = wbs_cyc_i ? H_ACK : IDLE;
            H_ACK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ack is raised while in H_ACK; an abort in H_WAIT never reaches it
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o     <= 1'b0;
            wbs_dat_o     <= '0;
            core_rvalid_o <= 1'b0;
        end else begin
            wbs_ack_o     <= (state == H_WAIT) & wbs_cyc_i;
            core_rvalid_o <= core_gnt & ~core_we_i;
            if (state == H_WAIT) begin
                wbs_dat_o <= sram_rdata_i;
            end
        end
    end

endmodule
